ask_bit_serializer: RTL

//   Upstream feeder of the ASK modulator: accepts parallel data words over a valid/ready

---
 rtl/ask_bit_serializer_if.sv | 33 +++
 rtl/ask_bit_serializer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ask_bit_serializer_if.sv
// Handshake and serial-output bundle between a word source, the ASK bit serializer
// and the downstream modulator.
interface ask_bit_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  data_bit;
    logic                  bit_strobe;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  data_bit,
        input  bit_strobe,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output data_bit,
        output bit_strobe,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/ask_bit_serializer.sv
// Frames each accepted word as start(1) + data bits + stop(0) and holds every bit
// for SAMPLES_PER_BIT clocks on data_bit; the line idles at 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line silent, ready for a word
// S_START | driving the start bit (1)
// S_DATA  | driving data bit bit_idx_q from the shift register
// S_STOP  | driving the stop bit (0); last clock may accept the next word
module ask_bit_serializer #(
    parameter int DATA_WIDTH      = 8,
    parameter int SAMPLES_PER_BIT = 32,
    parameter int MSB_FIRST       = 1
) (
    input  logic                clk,
    input  logic                rst,
    ask_bit_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  data_bit_q, data_bit_d;
    logic                  bit_strobe_q, bit_strobe_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  last_sample;
    logic                  tx_ready;
    logic                  accept;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] s);
        return (MSB_FIRST != 0) ? s[DATA_WIDTH-1] : s[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] s);
        return (MSB_FIRST != 0) ? (s << 1) : (s >> 1);
    endfunction

    assign last_sample = (sample_cnt_q == LAST_SAMPLE);
    // Ready only depends on registers, so the source never sees a loop through tx_valid.
    assign tx_ready    = (state_q == S_IDLE) || ((state_q == S_STOP) && last_sample);
    assign accept      = bus.tx_valid && tx_ready;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;

        unique case (state_q)
            S_IDLE: begin
                sample_cnt_d = '0;
                bit_idx_d    = '0;
                if (accept) begin
                    state_d = S_START;
                    shift_d = bus.tx_data;
                end
            end
            S_START: begin
                if (last_sample) begin
                    state_d      = S_DATA;
                    sample_cnt_d = '0;
                    bit_idx_d    = '0;
                end else begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (last_sample) begin
                    sample_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = S_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = advance(shift_q);
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (last_sample) begin
                    sample_cnt_d = '0;
                    bit_idx_d    = '0;
                    if (accept) begin
                        state_d = S_START;
                        shift_d = bus.tx_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d      = S_IDLE;
                sample_cnt_d = '0;
                bit_idx_d    = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        data_bit_d   = (state_d == S_START) || ((state_d == S_DATA) && out_bit(shift_d));
        bit_strobe_d = (state_d != S_IDLE) && (sample_cnt_d == '0);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (sample_cnt_d == LAST_SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_bit_q   <= 1'b0;
            bit_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_bit_q   <= data_bit_d;
            bit_strobe_q <= bit_strobe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tx_ready   = tx_ready;
    assign bus.data_bit   = data_bit_q;
    assign bus.bit_strobe = bit_strobe_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule
